// File: rtl/gfx_mem_bank.sv
// Generic graphics memory bank: CPU byte-write/read port and fill engine share port A,
// the video pipeline owns read-only port B. Depth need not be a power of two.
module gfx_mem_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_we,
    input  logic              cpu_re,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [BE_W-1:0]   cpu_be,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              vid_re,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_rvalid,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              fill_done
);

    // Handshake: cpu_we/cpu_re are single-cycle requests taken only while cpu_ready=1
    // (requests seen with cpu_ready=0 are dropped, not stalled); vid_re is always taken.
    // Each accepted read raises the matching rvalid for exactly one cycle, one cycle later,
    // and rdata keeps its last value whenever rvalid=0.

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_e;

    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   fill_cnt_q, fill_cnt_d;
    logic [DATA_W-1:0]   fill_val_q, fill_val_d;
    logic                fill_done_q, fill_done_d;

    logic [DATA_W-1:0]   cpu_rdata_q, vid_rdata_q;
    logic                cpu_rvalid_q, vid_rvalid_q;

    logic                cpu_in_range, vid_in_range;
    logic                cpu_rd_acc, cpu_wr_acc;

    logic                a_we;
    logic [ADDR_W-1:0]   a_addr;
    logic [DATA_W-1:0]   a_wdata;
    logic [BE_W-1:0]     a_be;

    logic [DATA_W-1:0]   mem [DEPTH];

    assign cpu_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q == ST_FILL);
    assign fill_done    = fill_done_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign cpu_rvalid   = cpu_rvalid_q;
    assign vid_rdata    = vid_rdata_q;
    assign vid_rvalid   = vid_rvalid_q;

    // Addresses in [DEPTH, 2**ADDR_W) exist on the bus but not in the array.
    assign cpu_in_range = ({1'b0, cpu_addr} < DEPTH_L);
    assign vid_in_range = ({1'b0, vid_addr} < DEPTH_L);
    assign cpu_rd_acc   = cpu_re & cpu_ready;
    assign cpu_wr_acc   = cpu_we & cpu_ready & cpu_in_range;

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        fill_val_d  = fill_val_q;
        fill_done_d = 1'b0;
        a_we        = 1'b0;
        a_addr      = cpu_addr;
        a_wdata     = cpu_wdata;
        a_be        = cpu_be;
        case (state_q)
            ST_IDLE: begin
                a_we = cpu_wr_acc;
                if (fill_start) begin
                    state_d    = ST_FILL;
                    fill_cnt_d = '0;
                    fill_val_d = fill_value;
                end
            end
            ST_FILL: begin
                a_we    = 1'b1;
                a_addr  = fill_cnt_q;
                a_wdata = fill_val_q;
                a_be    = '1;
                // Explicit terminal compare so power-of-two depths never rely on wrap.
                if (fill_cnt_q == LAST_ADDR) begin
                    state_d     = ST_IDLE;
                    fill_done_d = 1'b1;
                end else begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A reset cycle aborts the fill before its pending write lands.
        if (reset) begin
            a_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            fill_cnt_q  <= '0;
            fill_val_q  <= '0;
            fill_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            fill_val_q  <= fill_val_d;
            fill_done_q <= fill_done_d;
        end
    end

    // Array is never reset; byte lanes are written independently.
    always_ff @(posedge clk) begin
        if (a_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (a_be[i]) begin
                    mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read registers sample the array directly so reads see the pre-write word.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            cpu_rvalid_q <= cpu_rd_acc;
            if (cpu_rd_acc) begin
                cpu_rdata_q <= cpu_in_range ? mem[cpu_addr] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vid_rdata_q  <= '0;
            vid_rvalid_q <= 1'b0;
        end else begin
            vid_rvalid_q <= vid_re;
            if (vid_re) begin
                vid_rdata_q <= vid_in_range ? mem[vid_addr] : '0;
            end
        end
    end

endmodule

// File: doc/gfx_mem_bank.md
# gfx_mem_bank

Parametrised graphics memory bank for the tile/sprite video pipeline. One generic block replaces the fixed-size tile buffer, tile/sprite pattern, palette and OAM stores. It provides:
- a CPU-side port with byte-enable writes and a read-valid flag;
- an independent video-side read port;
- a hardware fill engine that clears or initialises the whole array without CPU involvement.

Non-power-of-two depths (e.g. the 300-entry tile map) are handled with defined out-of-range behaviour.

## Interface
- DATA_W, 32, word width in bits; multiple of 8
- DEPTH, 2048, number of words; any value ≥ 2
- ADDR_W, $clog2(DEPTH), address width
- BE_W, DATA_W/8, byte-enable width
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- cpu_we  input  1  CPU write strobe
- cpu_re  input  1  CPU read strobe
- cpu_addr  input  ADDR_W  CPU word address
- cpu_wdata  input  DATA_W  CPU write data
- cpu_be  input  BE_W  byte enables; bit i covers bits [8i+7:8i]
- cpu_ready  output  1  high when CPU accesses are accepted (= ~busy)
- cpu_rdata  output  DATA_W  CPU read data
- cpu_rvalid  output  1  cpu_rdata valid this cycle
- vid_re  input  1  video read strobe
- vid_addr  input  ADDR_W  video word address
- vid_rdata  output  DATA_W  video read data
- vid_rvalid  output  1  vid_rdata valid this cycle
- fill_start  input  1  start fill of the whole array
- fill_value  input  DATA_W  fill word, sampled on the accepted fill_start cycle
- busy  output  1  fill in progress
- fill_done  output  1  one-cycle pulse after the last fill write

## Operation
- Storage is DEPTH × DATA_W, inferred as a true dual-port RAM.
  - Port A is shared by the CPU and the fill engine.
  - Port B is video read only.
- The array is not cleared by reset. Contents are undefined until written or filled.
- **FSM state IDLE:**
  - CPU accesses are accepted.
  - fill_start=1 latches fill_value, clears the fill counter to 0, and moves to FILL.
- **FSM state FILL:**
  - Each cycle, writes the latched value (all bytes) at the counter address, then increments the counter.
  - On the cycle that writes address DEPTH-1, returns to IDLE and pulses fill_done the following cycle.
  - fill_start is ignored while in FILL.
- **CPU writes:** accepted only when cpu_ready=1. Only bytes with cpu_be[i]=1 are updated. cpu_be=0 is a legal no-op.
- **CPU reads:** accepted only when cpu_ready=1. CPU accesses presented while busy=1 are dropped: no write, no cpu_rvalid.
- **CPU read and write together** (same cycle, same address): the write is performed and the read returns the pre-write word (read-first).
- **Video reads:** never blocked, including during FILL.
  - vid_re with vid_addr equal to the address being written on port A in the same cycle returns the pre-write word.
- **Out-of-range addresses** (addr ≥ DEPTH):
  - Writes are discarded.
  - Reads return all-zero data with the normal valid pulse.
- **Reset** (any state, including mid-FILL) forces IDLE. The fill is aborted: words already written keep the fill value, remaining words are unchanged.

## Timing
- Reset values:
  - cpu_rdata = 0, cpu_rvalid = 0
  - vid_rdata = 0, vid_rvalid = 0
  - busy = 0, fill_done = 0, cpu_ready = 1
- Read latency is 1 cycle on both ports.
  - Strobe in cycle N → data and valid in cycle N+1.
  - rdata holds its last value when valid=0.
- Back-to-back reads on either port: one per cycle, full throughput.
- Write is visible to a read issued in the cycle after the write cycle on either port.
- Fill timing:
  - fill_start accepted in cycle N → busy=1 and cpu_ready=0 from N+1.
  - Writes occur in cycles N+1 … N+DEPTH.
  - busy=0 and fill_done=1 in cycle N+DEPTH+1.
  - The next fill_start is accepted in N+DEPTH+1.
- fill_start and a CPU access in the same IDLE cycle: the CPU access completes, and the fill begins the next cycle.
- Counter width is ADDR_W. For power-of-two DEPTH the terminal compare is against DEPTH-1, never relying on wrap.

## Test plan
- **Byte-enable write and readback.** DATA_W=32, DEPTH=2048: write 0xAABBCCDD to addr 5 with be=4'hF, then 0x11223344 with be=4'b0101, then read addr 5 → cpu_rdata=0xAA22CC44, cpu_rvalid=1 exactly one cycle after cpu_re.
- **Collision read-first.** Addr 7 holds 0x0; CPU writes 0x12345678 to addr 7 while vid_re reads addr 7 in the same cycle → vid_rdata=0x0. A video read the next cycle → 0x12345678.
- **Fill.** DEPTH=300, fill_value=0xDEADBEEF: busy high for exactly 300 cycles; fill_done pulses once; CPU write attempted during busy has no effect; video reads of addr 0 and addr 299 after done → 0xDEADBEEF.
- **Out-of-range.** DEPTH=300: write 0xFFFFFFFF to addr 300, then read addr 300 → rdata=0, rvalid=1. Addr 299 is unchanged.
- **Reset mid-fill.** Assert reset 10 cycles into a fill of 0x55 over prior contents 0xAA → busy=0 and all outputs at reset values the cycle after reset; addrs 0–8 read 0x55, addrs ≥ 10 read 0xAA.
- **Simultaneous start.** fill_start together with a CPU write of 0x1 to addr 3 → busy rises next cycle; addr 3 ends as the fill value.
